// File: rtl/aes_axis_out_serializer.sv
// AES result-block to AXI-Stream serializer.
// Accepted 128-bit blocks are queued in a small circular FIFO. A shifter stage
// takes one block at a time and emits it as four 32-bit words, most significant
// word first. tlast marks the final word of a block flagged with in_last.
module aes_axis_out_serializer #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                                m00_axis_aclk,
  input  logic                                m00_axis_aresetn,
  input  logic [127:0]                        in_blk,
  input  logic                                in_last,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic                                m00_axis_tvalid,
  input  logic                                m00_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_count
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int STRB_W = C_M_AXIS_TDATA_WIDTH / 8;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Select one 32-bit word of a block; index 0 is the most significant word.
  function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      2'd3:    w = blk[31:0];
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // FIFO storage: bit 128 carries the in_last flag alongside the block.
  logic [128:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Serializer state
  state_e        state_q;
  logic [1:0]    idx_q;
  logic [127:0]  blk_q;
  logic          last_q;
  logic          tvalid_q;
  logic [31:0]   tdata_q;
  logic          tlast_q;
  logic [STRB_W-1:0] tstrb_q;

  logic          push_s;
  logic          pop_s;
  logic          fifo_empty_s;
  logic          send_done_s;
  logic [128:0]  head_s;

  // in_ready depends on stored occupancy only, never on the downstream ready.
  assign in_ready   = (count_q < DEPTH_C);
  assign fifo_count = count_q;
  assign head_s     = mem_q[rd_ptr_q];

  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tstrb  = tstrb_q;

  // Handshake decode: a pop happens when the shifter is free (idle) or is
  // finishing its last word, so consecutive blocks stream without a bubble.
  always_comb begin
    push_s       = in_valid && in_ready;
    fifo_empty_s = (count_q == {(AW + 1){1'b0}});
    send_done_s  = (state_q == ST_SEND) && tvalid_q && m00_axis_tready && (idx_q == 2'd3);
    if (!fifo_empty_s) begin
      pop_s = (state_q == ST_IDLE) || send_done_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Next-state for FIFO pointers and occupancy; simultaneous push/pop keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW + 1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write; cleared on reset so no stale block can ever surface.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 129'd0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= {in_last, in_blk};
    end
  end

  // Serializer FSM with registered stream outputs; outputs hold while stalled.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      blk_q    <= 128'd0;
      last_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= 32'h0000_0000;
      tlast_q  <= 1'b0;
      tstrb_q  <= {STRB_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            state_q  <= ST_SEND;
            idx_q    <= 2'd0;
            blk_q    <= head_s[127:0];
            last_q   <= head_s[128];
            tvalid_q <= 1'b1;
            tdata_q  <= word_sel(head_s[127:0], 2'd0);
            tlast_q  <= 1'b0;
            tstrb_q  <= {STRB_W{1'b1}};
          end else begin
            state_q  <= ST_IDLE;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tstrb_q  <= {STRB_W{1'b0}};
          end
        end
        ST_SEND: begin
          if (tvalid_q && m00_axis_tready) begin
            if (idx_q == 2'd3) begin
              if (pop_s) begin
                // Back-to-back: next block's first word follows immediately.
                idx_q    <= 2'd0;
                blk_q    <= head_s[127:0];
                last_q   <= head_s[128];
                tvalid_q <= 1'b1;
                tdata_q  <= word_sel(head_s[127:0], 2'd0);
                tlast_q  <= 1'b0;
                tstrb_q  <= {STRB_W{1'b1}};
              end else begin
                state_q  <= ST_IDLE;
                idx_q    <= 2'd0;
                tvalid_q <= 1'b0;
                tdata_q  <= 32'h0000_0000;
                tlast_q  <= 1'b0;
                tstrb_q  <= {STRB_W{1'b0}};
              end
            end else begin
              idx_q   <= idx_q + 2'd1;
              tdata_q <= word_sel(blk_q, idx_q + 2'd1);
              tlast_q <= (idx_q == 2'd2) && last_q;
            end
          end else begin
            state_q <= ST_SEND;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          idx_q    <= 2'd0;
          tvalid_q <= 1'b0;
          tdata_q  <= 32'h0000_0000;
          tlast_q  <= 1'b0;
          tstrb_q  <= {STRB_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_axis_out_serializer.sv
// Directed bench for aes_axis_out_serializer: expected words are queued when a
// block is accepted and compared as the stream handshakes them out.
module tb_aes_axis_out_serializer;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_blk;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic         tvalid;
  logic         tready;
  logic [31:0]  tdata;
  logic [3:0]   tstrb;
  logic         tlast;
  logic [2:0]   fifo_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [32:0]  exp_q[$];
  int           beat_cyc_q[$];

  logic [32:0]  mon_e;
  logic [31:0]  prev_data;
  logic         prev_last;
  bit           prev_stall = 1'b0;

  aes_axis_out_serializer #(
    .C_M_AXIS_TDATA_WIDTH(32),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .m00_axis_aclk   (clk),
    .m00_axis_aresetn(rst_n),
    .in_blk          (in_blk),
    .in_last         (in_last),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .m00_axis_tvalid (tvalid),
    .m00_axis_tready (tready),
    .m00_axis_tdata  (tdata),
    .m00_axis_tstrb  (tstrb),
    .m00_axis_tlast  (tlast),
    .fifo_count      (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [127:0] blk, input logic last);
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back({(j == 3) && last, blk[127 - 32 * j -: 32]});
    end
  endtask

  // Present one block, wait (bounded) for in_ready, and queue its words.
  task automatic push_one(input logic [127:0] blk, input logic last);
    int n;
    in_blk   = blk;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    push_exp(blk, last);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) begin
      tick();
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  // Stream monitor: scoreboard compare, strobe check and stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", tvalid, 1'b1);
        chk("hold_data", tdata, prev_data);
        chk("hold_last", tlast, prev_last);
      end
      if (tvalid) chk("tstrb", tstrb, 4'hF);
      if (tvalid && tready) begin
        chk("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("tdata", tdata, mon_e[31:0]);
          chk("tlast", tlast, mon_e[32]);
        end
        beat_cyc_q.push_back(cyc);
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  initial begin
    logic [127:0] blks [6];
    logic [127:0] b;
    int acc_cyc;
    int k;
    bit rdy;

    rst_n    = 1'b0;
    in_blk   = 128'd0;
    in_last  = 1'b0;
    in_valid = 1'b0;
    tready   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tdata", tdata, 32'h0);
    chk("rst_tstrb", tstrb, 4'h0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1'b1);

    // Single block, tready=1: beat handshakes on the 2nd edge after accept.
    tready = 1'b1;
    beat_cyc_q.delete();
    push_one(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
    acc_cyc = cyc;
    chk("no_bypass", tvalid, 1'b0);
    drain(40);
    chk("single_beats", beat_cyc_q.size(), 4);
    for (int j = 0; j < 4 && j < beat_cyc_q.size(); j++) begin
      chk("single_timing", beat_cyc_q[j], acc_cyc + 1 + j);
    end
    tick();
    chk("single_idle", tvalid, 1'b0);
    chk("single_count", fifo_count, 3'd0);

    // Same block, tready high one cycle in 16.
    tready = 1'b0;
    beat_cyc_q.delete();
    push_one(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
      tready = ((n % 16) == 15);
      tick();
    end
    chk("slow_drain", exp_q.size(), 0);
    chk("slow_beats", beat_cyc_q.size(), 4);
    tready = 1'b0;
    tick();
    chk("slow_idle", tvalid, 1'b0);

    // Backpressure fill: 6 distinct blocks offered, 5 fit.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) begin
        b[127 - 32 * j -: 32] = 32'hA000_0000 + (i << 8) + j;
      end
      blks[i] = b;
    end
    beat_cyc_q.delete();
    k = 0;
    in_valid = 1'b1;
    for (int n = 0; n < 14; n++) begin
      in_blk  = blks[k];
      in_last = (k >= 4);
      rdy     = in_ready;
      tick();
      if (rdy) begin
        push_exp(blks[k], k >= 4);
        if (k < 5) k++;
      end
    end
    chk("fill_accepted", k, 5);
    chk("fill_in_ready", in_ready, 1'b0);
    chk("fill_count", fifo_count, 3'd4);
    chk("fill_tvalid", tvalid, 1'b1);
    in_valid = 1'b0;
    tready   = 1'b1;
    drain(60);
    chk("fill_beats", beat_cyc_q.size(), 20);
    if (beat_cyc_q.size() == 20) chk("fill_rate", beat_cyc_q[19] - beat_cyc_q[0], 19);
    tick();
    chk("fill_idle_count", fifo_count, 3'd0);

    // Two blocks back to back: 8 continuous beats, tlast only on beat 8.
    beat_cyc_q.delete();
    push_one(128'h11111111_22222222_33333333_44444444, 1'b0);
    push_one(128'h55555555_66666666_77777777_88888888, 1'b1);
    drain(40);
    chk("b2b_beats", beat_cyc_q.size(), 8);
    if (beat_cyc_q.size() == 8) chk("b2b_rate", beat_cyc_q[7] - beat_cyc_q[0], 7);

    // Reset after word 2 of a block, with another block queued.
    beat_cyc_q.delete();
    push_one(128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3, 1'b1);
    push_one(128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3, 1'b1);
    for (int n = 0; n < 20 && beat_cyc_q.size() < 2; n++) tick();
    chk("mid_two_beats", beat_cyc_q.size(), 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", tvalid, 1'b0);
    chk("mid_rst_count", fifo_count, 3'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    beat_cyc_q.delete();
    for (int n = 0; n < 10; n++) tick();
    chk("post_rst_silent", beat_cyc_q.size(), 0);
    chk("post_rst_tvalid", tvalid, 1'b0);
    push_one(128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3, 1'b1);
    drain(40);
    chk("post_rst_beats", beat_cyc_q.size(), 4);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_axis_out_serializer.md
AES_AXIS_OUT_SERIALIZER -- requirements
Module: aes_axis_out_serializer

Interface
REQ-001 SHALL have parameter C_M_AXIS_TDATA_WIDTH, default 32, stream word width; only 32 is supported.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, block FIFO depth in 128-bit blocks; power of 2, >=2.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port m00_axis_aclk, input, 1 bit: clock; all logic on its rising edge.
REQ-005 SHALL have port m00_axis_aresetn, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port in_blk, input, 128 bits: AES result block.
REQ-007 SHALL have port in_last, input, 1 bit: block is the final block of its packet.
REQ-008 SHALL have port in_valid, input, 1 bit: in_blk/in_last valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepted on the edge where in_valid && in_ready.
REQ-010 SHALL have port m00_axis_tvalid, output, 1 bit: AXI-Stream master valid.
REQ-011 SHALL have port m00_axis_tready, input, 1 bit: downstream ready.
REQ-012 SHALL have port m00_axis_tdata, output, 32 bits: stream word.
REQ-013 SHALL have port m00_axis_tstrb, output, 4 bits: byte strobes.
REQ-014 SHALL have port m00_axis_tlast, output, 1 bit: last word of packet.
REQ-015 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: blocks held in FIFO, excluding the shifter.

Function
REQ-016 SHALL store accepted blocks plus in_last in a circular FIFO.
- Read/write pointers wrap modulo FIFO_DEPTH.
- Full/empty derived from fifo_count.
REQ-017 SHALL drive in_ready = (fifo_count < FIFO_DEPTH).
- Registered-state function only; no combinational path from m00_axis_tready.
REQ-018 SHALL implement serializer FSM with states IDLE and SEND plus a 2-bit word index.
REQ-019 IDLE, FIFO non-empty:
- Pop head into 128-bit shift register on that edge.
- Go to SEND, word index 0, m00_axis_tvalid=1 after the edge.
REQ-020 SHALL emit words MSW first: index 0 = blk[127:96], 1 = blk[95:64], 2 = blk[63:32], 3 = blk[31:0].
REQ-021 SHALL register all stream outputs; tdata/tlast SHALL stay stable while tvalid && !tready.
REQ-022 SHALL advance word index only on tvalid && tready.
REQ-023 SHALL assert tlast only at word index 3 of a block whose in_last=1.
REQ-024 Word index 3 accepted, FIFO non-empty:
- Pop the next block on the same edge; tvalid stays 1 with no bubble.
REQ-025 Word index 3 accepted, FIFO empty: return to IDLE, tvalid=0.
REQ-026 Simultaneous push and pop SHALL leave fifo_count unchanged.
- Push while FIFO empty SHALL NOT bypass the FIFO: first word appears 2 edges after the input handshake edge.
REQ-027 SHALL drive m00_axis_tstrb = 4'hF whenever tvalid=1.
REQ-028 Steady-state throughput SHALL be one word per cycle when tready=1.

Reset
REQ-029 m00_axis_aresetn=0 SHALL immediately, asynchronously clear:
- FSM=IDLE, word index=0, pointers=0, fifo_count=0.
- tvalid=0, tlast=0, tdata=0, tstrb=0.
REQ-030 in_ready SHALL be 1 from the first edge after reset release (fifo_count=0).
REQ-031 Reset mid-packet SHALL discard the partial block and all FIFO contents.
- No word is emitted after release until new input arrives.

Verification
REQ-032 Single block, tready=1:
- Stimulus: in_blk=00112233_44556677_8899AABB_CCDDEEFF, in_last=1.
- Response: beats 00112233, 44556677, 8899AABB, CCDDEEFF on consecutive cycles.
- First beat 2 edges after accept; tlast on beat 4 only.
REQ-033 Same block, tready high one cycle in 16:
- Each word held stable until accepted; 4 beats total; tvalid never drops mid-block.
REQ-034 tready=0, in_valid held with 6 distinct blocks:
- 5 blocks accepted (1 shifter + 4 FIFO), then in_ready=0 with fifo_count=4.
- Raising tready drains 20 words in order.
REQ-035 Two blocks (in_last=0, then 1), tready=1:
- 8 back-to-back beats; tvalid continuous; tlast on beat 8 only.
REQ-036 Reset asserted after word 2 of a block:
- tvalid=0 immediately, fifo_count=0.
- After release, no output until a new block arrives; the new block's 4 words appear correctly.
